// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: opcodes, exception codes, FSM states and access-size decode shared by the M-stage LSU.
package mips_mem_pkg;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction
    // opcode bit 1 marks word ops, bit 0 halfword ops; bit 3 stores, bit 2 unsigned loads
    function automatic logic [1:0] op_size(input logic [5:0] op);
        return op[1] ? SZ_WORD : op[0] ? SZ_HALF : SZ_BYTE;
    endfunction
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store lane replication and load extract/extend for either endianness.
module lsu_lane_align
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 0
) (
    input  logic        is_load,
    input  logic        is_unsigned,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [1:0]  b_lane;
    logic        h_lane;
    logic [7:0]  b;
    logic [15:0] h;
    // big-endian mirrors the lane numbering, so flipping the lane index covers both ends
    always_comb begin
        b_lane    = addr_lo ^ {2{BIG_ENDIAN}};
        h_lane    = addr_lo[1] ^ BIG_ENDIAN;
        b         = rdata[{b_lane, 3'b000} +: 8];
        h         = rdata[{h_lane, 4'b0000} +: 16];
        be        = (is_load || size == SZ_WORD) ? 4'b1111 :
                    size == SZ_HALF ? (h_lane ? 4'b1100 : 4'b0011) : 4'b0001 << b_lane;
        wdata_rep = size == SZ_WORD ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        rdata_ext = size == SZ_WORD ? rdata :
                    size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : {{24{b[7] & ~is_unsigned}}, b};
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: sequential M-stage load/store unit with req/ack bus, alignment checks,
// bus-timeout watchdog, precise exceptions and flush handling.
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [5:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic              flush,
    output logic              in_ready,
    output logic              stall,
    output logic              out_done,
    output logic [31:0]       out_rdata,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [ADDR_W-1:0] exc_badvaddr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    lsu_state_e        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              flushed_q, flushed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idle, waiting, in_mis, accept, timeout, killed;
    logic [5:0]        a_op;
    logic [3:0]        a_be;
    logic [31:0]       a_wdata, a_rdata;

    assign idle    = state_q == ST_IDLE;
    assign waiting = state_q == ST_WAIT;
    assign in_mis  = misaligned(op_size(in_op), in_addr[1:0]);
    assign accept  = idle && in_valid && is_mem_op(in_op) && !in_mis && !flush;
    assign timeout = (TIMEOUT != 0) && cnt_q == CNT_W'(TIMEOUT - 1);
    assign killed  = flushed_q || flush;
    // one aligner serves the incoming request in IDLE and the held op's response in WAIT
    assign a_op    = idle ? in_op : op_q;

    lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .is_load    (!a_op[3]),
        .is_unsigned(a_op[2]),
        .size       (op_size(a_op)),
        .addr_lo    (idle ? in_addr[1:0] : addr_q[1:0]),
        .wdata      (in_wdata),
        .rdata      (bus_rdata),
        .be         (a_be),
        .wdata_rep  (a_wdata),
        .rdata_ext  (a_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            flushed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            flushed_q <= flushed_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        flushed_d = flushed_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d   = ST_WAIT;
                op_d      = in_op;
                addr_d    = in_addr;
                be_d      = a_be;
                wdata_d   = a_wdata;
                flushed_d = 1'b0;
                cnt_d     = '0;
            end
            ST_WAIT: begin
                cnt_d     = cnt_q + 1'b1;
                flushed_d = killed;
                if (bus_ack) begin
                    state_d = killed ? ST_IDLE : ST_DONE;
                    rdata_d = op_q[3] ? '0 : a_rdata;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = idle;
        stall        = accept || waiting;
        out_done     = state_q == ST_DONE && !flush;
        out_rdata    = out_done ? rdata_q : '0;
        bus_req      = waiting;
        bus_we       = waiting && op_q[3];
        bus_addr     = waiting ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus_be       = waiting ? be_q : '0;
        bus_wdata    = waiting ? wdata_q : '0;
        exc_valid    = (idle && in_valid && is_mem_op(in_op) && in_mis && !flush) ||
                       (waiting && timeout && !bus_ack && !killed);
        exc_code     = !exc_valid ? '0 : !idle ? EXC_DBE : in_op[3] ? EXC_ADES : EXC_ADEL;
        exc_badvaddr = !exc_valid ? '0 : idle ? in_addr : addr_q;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu (little- and big-endian
// instances, TIMEOUT = 8) against a byte-address reference model.
module tb_mem_stage_lsu;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LW = 6'b100011, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100;

    typedef struct {
        int stall_n; int done_n; int done_cyc; int exc_n; int exc_cyc; int req_n;
        logic [31:0] rdata; logic [4:0] code; logic [31:0] bad;
        logic [3:0] be; logic [31:0] bwd; logic [31:0] baddr; logic bwe;
        bit unstable; bit hung;
    } obs_t;

    logic clk = 0, reset_n = 0, in_valid = 0, flush = 0, bus_ack = 0;
    logic [5:0] in_op = 0;
    logic [31:0] in_addr = 0, in_wdata = 0, bus_rdata = 0;
    wire [1:0] rdy, stl, done, excv, req, we;
    wire [1:0][31:0] ordata, bad, baddr, bwdata;
    wire [1:0][4:0] code;
    wire [1:0][3:0] be;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_lsu #(.ADDR_W(32), .BIG_ENDIAN(g == 1), .TIMEOUT(8)) dut (
            .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
            .in_wdata(in_wdata), .flush(flush), .in_ready(rdy[g]), .stall(stl[g]), .out_done(done[g]),
            .out_rdata(ordata[g]), .exc_valid(excv[g]), .exc_code(code[g]), .exc_badvaddr(bad[g]),
            .bus_req(req[g]), .bus_we(we[g]), .bus_addr(baddr[g]), .bus_be(be[g]),
            .bus_wdata(bwdata[g]), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
        );
    end

    function automatic int nbytes(logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_store(logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic int lane(int a, bit big);
        return big ? 3 - a : a;
    endfunction

    function automatic logic [3:0] exp_be(logic [5:0] op, logic [1:0] a, bit big);
        logic [3:0] m = 0;
        if (!is_store(op)) return 4'hF;
        for (int i = 0; i < nbytes(op); i++) m[lane(int'(a) + i, big)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [5:0] op, logic [31:0] w);
        int n = nbytes(op);
        return n == 1 ? {4{w[7:0]}} : n == 2 ? {2{w[15:0]}} : w;
    endfunction

    function automatic logic [31:0] exp_load(logic [5:0] op, logic [1:0] a, logic [31:0] rd, bit big);
        int n = nbytes(op);
        logic [31:0] v = 0;
        logic [7:0] byt;
        for (int i = 0; i < n; i++) begin
            byt = 8'(rd >> (8 * lane(int'(a) + i, big)));
            v = big ? ((v << 8) | 32'(byt)) : (v | (32'(byt) << (8 * i)));
        end
        if (!(op inside {LBU, LHU}) && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic bit is_misaligned(logic [5:0] op, logic [1:0] a);
        return int'(a) % nbytes(op) != 0;
    endfunction

    // Presents one op, acks in WAIT cycle ack_lat (-1 never), pulses flush in cycle flush_at
    // after acceptance (-1 never), and records what the selected DUT did until it is idle again.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                          input int ack_lat, flush_at, input bit big, output obs_t o);
        int b = big ? 1 : 0;
        o = '{default: 0};
        o.hung = 1;
        @(posedge clk); #1;
        flush = 0; bus_ack = 0;
        in_valid = 1; in_op = op; in_addr = addr; in_wdata = wdata;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                in_valid = 0;
                bus_ack = (c - 1 == ack_lat);
                bus_rdata = bus_ack ? rdata : $urandom;
                flush = (c - 1 == flush_at);
            end
            @(negedge clk);
            if (stl[b]) o.stall_n++;
            if (req[b]) begin
                if (o.req_n == 0) {o.be, o.bwd, o.baddr, o.bwe} = {be[b], bwdata[b], baddr[b], we[b]};
                else if ({be[b], bwdata[b], baddr[b], we[b]} !== {o.be, o.bwd, o.baddr, o.bwe}) o.unstable = 1;
                o.req_n++;
            end
            if (done[b]) begin o.done_n++; o.done_cyc = c; o.rdata = ordata[b]; end
            if (excv[b]) begin o.exc_n++; o.exc_cyc = c; o.code = code[b]; o.bad = bad[b]; end
            @(posedge clk); #1;
            if (c > 1 && rdy[b] && !stl[b]) begin o.hung = 0; break; end
        end
        in_valid = 0; bus_ack = 0; flush = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (rdy !== 2'b11) $display("FAIL reset_in_ready got %b exp 11", rdy); else passed++;
        total++; if ({stl, done, excv, req, we} !== 10'b0) $display("FAIL reset_ctrl got %b exp 0", {stl, done, excv, req, we}); else passed++;
        total++; if ({ordata[0], bad[0], baddr[0], be[0], bwdata[0], code[0]} !== '0) $display("FAIL reset_data got nonzero exp 0"); else passed++;
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_sb();
        obs_t o;
        run_op(SB, 32'h1002, 32'h0000_00AB, 0, 3, -1, 0, o);
        total++; if (o.be !== 4'b0100) $display("FAIL sb_be got %b exp 0100", o.be); else passed++;
        total++; if (o.bwd !== 32'hABABABAB) $display("FAIL sb_wdata got %h exp ababab", o.bwd); else passed++;
        total++; if (o.baddr !== 32'h1000 || o.bwe !== 1'b1) $display("FAIL sb_addr got %h/%b exp 1000/1", o.baddr, o.bwe); else passed++;
        total++; if (o.stall_n !== 4) $display("FAIL sb_stall got %0d exp 4", o.stall_n); else passed++;
        total++; if (o.done_n !== 1 || o.done_cyc !== 5) $display("FAIL sb_done got %0d@%0d exp 1@5", o.done_n, o.done_cyc); else passed++;
        total++; if (o.rdata !== 0 || o.exc_n !== 0 || o.unstable) $display("FAIL sb_misc got rd %h exc %0d unst %0d exp 0", o.rdata, o.exc_n, o.unstable); else passed++;
    endtask

    task automatic test_loads();
        obs_t o;
        run_op(LB, 32'h2003, 0, 32'h80FF1234, 2, -1, 0, o);
        total++; if (o.rdata !== 32'hFFFFFF80 || o.done_n !== 1) $display("FAIL lb_le got %h (%0d) exp ffffff80", o.rdata, o.done_n); else passed++;
        total++; if (o.be !== 4'hF || o.bwe !== 0 || o.baddr !== 32'h2000) $display("FAIL lb_bus got %b/%b/%h exp 1111/0/2000", o.be, o.bwe, o.baddr); else passed++;
        run_op(LBU, 32'h2003, 0, 32'h80FF1234, 1, -1, 0, o);
        total++; if (o.rdata !== 32'h80) $display("FAIL lbu_le got %h exp 00000080", o.rdata); else passed++;
        run_op(LB, 32'h2003, 0, 32'h80FF1234, 2, -1, 1, o);
        total++; if (o.rdata !== 32'h34 || o.be !== 4'hF) $display("FAIL lb_be got %h/%b exp 00000034/1111", o.rdata, o.be); else passed++;
        run_op(LH, 32'h2002, 0, 32'h80FF1234, 1, -1, 1, o);
        total++; if (o.rdata !== 32'h1234) $display("FAIL lh_be got %h exp 00001234", o.rdata); else passed++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(LH, 32'h3001, 0, 0, 1, -1, 0, o);
        total++; if (o.exc_n !== 1 || o.exc_cyc !== 1 || o.code !== 5'd4 || o.bad !== 32'h3001) $display("FAIL adel got %0d@%0d code %0d bad %h exp 1@1 4 3001", o.exc_n, o.exc_cyc, o.code, o.bad); else passed++;
        total++; if (o.req_n !== 0 || o.stall_n !== 0 || o.done_n !== 0) $display("FAIL adel_bus got req %0d stall %0d exp 0", o.req_n, o.stall_n); else passed++;
        run_op(SW, 32'h3002, 0, 0, 1, -1, 0, o);
        total++; if (o.exc_n !== 1 || o.code !== 5'd5 || o.bad !== 32'h3002) $display("FAIL ades got %0d code %0d bad %h exp 1 5 3002", o.exc_n, o.code, o.bad); else passed++;
        flush = 1;
        @(negedge clk);
        in_valid = 1; in_op = LH; in_addr = 32'h3001; #1;
        total++; if (excv[0] !== 0 || stl[0] !== 0) $display("FAIL flush_idle_exc got exc %b stall %b exp 0 0", excv[0], stl[0]); else passed++;
        in_addr = 32'h3000;
        @(negedge clk);
        total++; if (req[0] !== 0 || rdy[0] !== 1) $display("FAIL flush_idle_accept got req %b rdy %b exp 0 1", req[0], rdy[0]); else passed++;
        in_valid = 0; flush = 0;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(LW, 32'h5000, 0, 0, -1, -1, 0, o);
        total++; if (o.exc_n !== 1 || o.exc_cyc !== 9 || o.code !== 5'd7 || o.bad !== 32'h5000) $display("FAIL dbe got %0d@%0d code %0d bad %h exp 1@9 7 5000", o.exc_n, o.exc_cyc, o.code, o.bad); else passed++;
        total++; if (o.req_n !== 8 || o.done_n !== 0 || o.hung) $display("FAIL dbe_bus got req %0d done %0d hung %0d exp 8 0 0", o.req_n, o.done_n, o.hung); else passed++;
        @(negedge clk);
        total++; if (rdy[0] !== 1 || req[0] !== 0) $display("FAIL dbe_idle got rdy %b req %b exp 1 0", rdy[0], req[0]); else passed++;
        run_op(LW, 32'h5004, 0, 32'hCAFEF00D, 8, -1, 0, o);
        total++; if (o.exc_n !== 0 || o.done_n !== 1 || o.rdata !== 32'hCAFEF00D) $display("FAIL ack_at_timeout got exc %0d done %0d rd %h exp 0 1 cafef00d", o.exc_n, o.done_n, o.rdata); else passed++;
    endtask

    task automatic test_flush();
        obs_t o;
        run_op(SH, 32'h4002, 32'h0000BEEF, 0, 6, 1, 0, o);
        total++; if (o.be !== 4'b1100 || o.unstable || o.req_n !== 6) $display("FAIL flush_wait_bus got be %b unst %0d req %0d exp 1100 0 6", o.be, o.unstable, o.req_n); else passed++;
        total++; if (o.done_n !== 0 || o.exc_n !== 0 || o.hung) $display("FAIL flush_wait got done %0d exc %0d hung %0d exp 0 0 0", o.done_n, o.exc_n, o.hung); else passed++;
        run_op(LW, 32'h4008, 0, 32'h12345678, 2, 3, 0, o);
        total++; if (o.done_n !== 0 || o.exc_n !== 0) $display("FAIL flush_done got done %0d exc %0d exp 0 0", o.done_n, o.exc_n); else passed++;
    endtask

    task automatic test_async_reset();
        obs_t o;
        logic [31:0] rd = $urandom;
        @(posedge clk); #1;
        in_valid = 1; in_op = LW; in_addr = 32'h6000;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #3;
        total++; if (req[0] !== 1) $display("FAIL pre_reset_req got %b exp 1", req[0]); else passed++;
        reset_n = 0; #1;
        total++; if (req[0] !== 0 || stl[0] !== 0 || excv[0] !== 0 || rdy[0] !== 1) $display("FAIL async_reset got req %b stall %b exc %b rdy %b exp 0 0 0 1", req[0], stl[0], excv[0], rdy[0]); else passed++;
        @(negedge clk); reset_n = 1;
        run_op(LW, 32'h6004, 0, rd, 2, -1, 0, o);
        total++; if (o.done_n !== 1 || o.done_cyc !== 4 || o.rdata !== rd) $display("FAIL post_reset_lw got %0d@%0d %h exp 1@4 %h", o.done_n, o.done_cyc, o.rdata, rd); else passed++;
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADDI, BEQ};
        obs_t o;
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op = ops[$urandom_range(9)];
            logic [31:0] a = $urandom, w = $urandom, rd = $urandom;
            int lat = $urandom_range(1, 5);
            bit big = 1'($urandom);
            run_op(op, a, w, rd, lat, -1, big, o);
            if (nbytes(op) == 0) begin
                total++; if (o.stall_n !== 0 || o.req_n !== 0 || o.exc_n !== 0 || o.done_n !== 0) $display("FAIL rnd_nonmem op %b got stall %0d req %0d exc %0d done %0d exp 0", op, o.stall_n, o.req_n, o.exc_n, o.done_n); else passed++;
            end else if (is_misaligned(op, a[1:0])) begin
                total++; if (o.exc_n !== 1 || o.code !== (is_store(op) ? 5'd5 : 5'd4) || o.bad !== a || o.req_n !== 0) $display("FAIL rnd_mis op %b a %h got exc %0d code %0d bad %h req %0d", op, a, o.exc_n, o.code, o.bad, o.req_n); else passed++;
            end else begin
                total++; if (o.be !== exp_be(op, a[1:0], big) || o.baddr !== {a[31:2], 2'b00} || o.bwe !== is_store(op) || o.unstable) $display("FAIL rnd_bus op %b a %h big %0d got be %b addr %h we %b exp be %b", op, a, big, o.be, o.baddr, o.bwe, exp_be(op, a[1:0], big)); else passed++;
                if (is_store(op)) begin
                    total++; if (o.bwd !== exp_wdata(op, w)) $display("FAIL rnd_wdata op %b got %h exp %h", op, o.bwd, exp_wdata(op, w)); else passed++;
                end
                total++; if (o.rdata !== (is_store(op) ? 32'h0 : exp_load(op, a[1:0], rd, big))) $display("FAIL rnd_rdata op %b a %h big %0d rd %h got %h", op, a, big, rd, o.rdata); else passed++;
                total++; if (o.stall_n !== lat + 1 || o.done_n !== 1 || o.done_cyc !== lat + 2 || o.exc_n !== 0) $display("FAIL rnd_timing op %b lat %0d got stall %0d done %0d@%0d exc %0d", op, lat, o.stall_n, o.done_n, o.done_cyc, o.exc_n); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_loads();
        test_misaligned();
        test_timeout();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Sequential load/store unit for the M pipeline stage of the MIPS core. Successor to the combinational memory-stage controller.
- Accepts one load/store per request from M and checks alignment. Drives a variable-latency data bus with a req/ack handshake, including byte-enable generation and write-lane replication.
- Extracts and sign/zero-extends load data. Raises stall while a bus access is in flight.
- Adds endianness selection, a bus-timeout watchdog, precise address/bus exceptions and flush handling.

Parameters:
- ADDR_W, 32, byte-address width (data width fixed at 32, 4 byte lanes).
- BIG_ENDIAN, 0, 0 = lane k holds byte address k; 1 = lane k holds byte address 3-k.
- TIMEOUT, 255, maximum cycles waiting for bus_ack before a bus error; 0 disables the watchdog.

Ports:
- clk, input, 1, clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, M stage presents a memory op.
- in_op, input, 6, MIPS opcode: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011. Any other opcode is a non-memory op.
- in_addr, input, ADDR_W, effective byte address.
- in_wdata, input, 32, store source register (value in low bits).
- flush, input, 1, kill the current op (exception or branch squash upstream).
- in_ready, output, 1, high in IDLE only.
- stall, output, 1, freeze the pipeline.
- out_done, output, 1, 1-cycle pulse: op complete.
- out_rdata, output, 32, extended load result, valid with out_done.
- exc_valid, output, 1, 1-cycle exception pulse.
- exc_code, output, 5, 4 = AdEL, 5 = AdES, 7 = DBE.
- exc_badvaddr, output, ADDR_W, faulting address.
- bus_req, bus_we, output, 1 each, bus request and write flag.
- bus_addr, output, ADDR_W, word-aligned address (low 2 bits 0).
- bus_be, output, 4, byte enables.
- bus_wdata, output, 32, replicated write data.
- bus_ack, input, 1, bus completion.
- bus_rdata, input, 32, read word, valid with bus_ack.

Behaviour:
- Reset (async, reset_n low): state IDLE. All outputs 0 except in_ready = 1. Timeout counter 0. Deassertion takes effect at the next clk edge; an in-flight bus access is dropped.
- Non-memory op with in_valid: no action, no stall, no pulse.
- Alignment rules: halfword ops need addr[0] = 0; word ops need addr[1:0] = 0.
- Misaligned op in IDLE: same cycle exc_valid = 1, code 4 (loads) or 5 (stores), exc_badvaddr = in_addr. No bus access; stays IDLE.
- Byte enables, lane-index form (BIG_ENDIAN = 0):
  - SW: 1111.
  - SH: 0011 or 1100 by addr[1].
  - SB: one-hot at addr[1:0].
- BIG_ENDIAN = 1: bus_be is bit-reversed.
- Write data: SB replicates byte x4; SH replicates halfword x2; SW passes through.
- Loads: bus_be = 1111.
- FSM states: IDLE, WAIT, DONE.
- IDLE -> WAIT on an aligned memory op with in_valid and not flush.
  - Registers op, addr, BE and wdata.
  - bus_req = 1 from the next cycle.
  - stall is combinationally 1 in the accepting cycle and throughout WAIT.
- WAIT:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - Counter increments each cycle.
  - On bus_ack: bus_req drops the next cycle. The selected lane(s) of bus_rdata are captured and extended (LB/LH sign, LBU/LHU zero; LW whole word). Go to DONE.
  - If the counter reaches TIMEOUT before an ack: exc_valid, code 7, badvaddr = held address, bus_req drops, go to IDLE.
  - An ack in the same cycle as the timeout wins.
- DONE: out_done = 1 for one cycle (stores too, out_rdata = 0), stall = 0, then IDLE. Total latency = bus ack latency + 2 cycles.
- flush:
  - In IDLE it suppresses acceptance and exceptions.
  - In WAIT it is latched; the bus transaction still completes to ack (never abandoned), then returns to IDLE with no out_done.
  - In DONE it suppresses out_done.
- Simultaneous in_valid while not in IDLE: ignored; the pipeline must hold due to stall.

Decomposition:
- Shared package mips_mem_pkg:
  - opcode constants.
  - exc_code constants (EXC_ADEL, EXC_ADES, EXC_DBE).
  - state enum.
  - size encoding (byte/half/word).
- One combinational sub-module, lsu_lane_align. It produces the BE, write replication and the load extract/extend per endianness, and is shared by the request and response paths.

Test Plan:
- SB addr 0x1002, wdata 0x000000AB, LE, ack after 3 cycles -> bus_be 0100, bus_wdata 0xABABABAB, bus_addr 0x1000, stall for 4 cycles, out_done on cycle 5.
- LB addr 0x2003, bus_rdata 0x80FF1234, LE -> out_rdata 0xFFFFFF80; same with LBU -> 0x00000080; BIG_ENDIAN = 1 LB -> 0x00000034, bus_be 1111.
- LH addr 0x3001 -> exc_valid, code 4, badvaddr 0x3001, no bus_req; SW addr 0x3002 -> code 5.
- LW, bus_ack never arrives, TIMEOUT = 8 -> exc code 7 at the 8th WAIT cycle, bus_req low after, in_ready = 1.
- SH addr 0x4002 accepted, flush pulsed in WAIT, ack 5 cycles later -> bus_be 1100 held until ack, no out_done, no exception.
- reset_n pulsed low mid-WAIT -> bus_req, stall and exc_valid immediately 0, in_ready 1; the next LW completes normally.
